// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing NUM_PORTS register-file read muxes among NUM_REQ requesters.
// Optional write-back bypass of the captured data is enabled by defining RF_WB_BYPASS_EN.
module regfile_read_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][4:0]            req_addr,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_PORTS-1:0][4:0]          rd_addr,
  input  logic [NUM_PORTS-1:0][63:0]         rd_data,
  input  logic                               wr_en,
  input  logic [4:0]                         wr_addr,
  input  logic [63:0]                        wr_data,
  output logic [NUM_REQ-1:0]                 resp_valid,
  output logic [NUM_REQ-1:0][63:0]           resp_data
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0]                     ptr;
  logic [PW-1:0]                     ptr_nxt;
  logic                              any_gnt;
  logic [NUM_REQ-1:0][NUM_PORTS-1:0] sel;
  logic [NUM_REQ-1:0][63:0]          cap;

  // Scan order ptr, ptr+1, ... ; the k-th winner takes port k. Nested loops keep
  // every index a compile-time loop variable instead of a computed one.
  always_comb begin
    int unsigned idx;
    int unsigned cnt;
    int unsigned last;
    int unsigned nxt;
    gnt     = '0;
    rd_addr = '0;
    sel     = '0;
    any_gnt = 1'b0;
    ptr_nxt = ptr;
    cnt     = 0;
    last    = 0;
    nxt     = 0;
    idx     = 0;
    if (reset_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (i == idx && req[i] && cnt < NUM_PORTS) begin
            gnt[i] = 1'b1;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (p == cnt) begin
                sel[i][p]  = 1'b1;
                rd_addr[p] = req_addr[i];
              end
            end
            last = i;
            cnt  = cnt + 1;
          end
        end
      end
      if (cnt != 0) begin
        any_gnt = 1'b1;
        nxt     = (last + 1 == NUM_REQ) ? 0 : last + 1;
        ptr_nxt = PW'(nxt);
      end
    end
  end

  always_comb begin
    cap = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (sel[i][p]) cap[i] = rd_data[p];
      end
`ifdef RF_WB_BYPASS_EN
      if (wr_en && wr_addr == req_addr[i] && wr_addr != 5'd31) cap[i] = wr_data;
`endif
    end
  end

`ifndef RF_WB_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= gnt;
      if (any_gnt) ptr <= ptr_nxt;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) resp_data[i] <= cap[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (NUM_REQ=4, NUM_PORTS=2) with a small register-file model.
module tb_regfile_read_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned NP = 2;
  localparam logic [63:0] BASE = 64'hAAAA_0000_0000_0000;

  logic                 clk;
  logic                 reset_n;
  logic [NR-1:0]        req;
  logic [NR-1:0][4:0]   req_addr;
  logic [NR-1:0]        gnt;
  logic [NP-1:0][4:0]   rd_addr;
  logic [NP-1:0][63:0]  rd_data;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [63:0]          wr_data;
  logic [NR-1:0]        resp_valid;
  logic [NR-1:0][63:0]  resp_data;

  logic [63:0] rf [32];
  int vectors = 0;
  int errors  = 0;

  regfile_read_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int p = 0; p < NP; p++) rd_data[p] = rf[rd_addr[p]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] bypass_exp;
    for (int a = 0; a < 32; a++) rf[a] = BASE | 64'(a);
    reset_n  = 1'b0;
    req      = 4'b1111;
    req_addr = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    // Reset: outputs forced low even with requests pending
    #2;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rd_addr", 64'(rd_addr), 64'h0);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_resp_data0", resp_data[0], 64'h0);
    chk("rst_ptr", 64'(dut.ptr), 64'h0);
    tick();
    tick();
    reset_n = 1'b1;
    req     = 4'b0000;
    tick();

    // Single request
    req = 4'b0001; req_addr[0] = 5'd5;
    #1;
    chk("single_gnt", 64'(gnt), 64'h1);
    chk("single_rd_addr0", 64'(rd_addr[0]), 64'd5);
    chk("single_rd_addr1", 64'(rd_addr[1]), 64'd0);
    tick();
    req = 4'b0000;
    chk("single_resp_valid", 64'(resp_valid), 64'h1);
    chk("single_resp_data0", resp_data[0], 64'hAAAA_0000_0000_0005);
    chk("single_ptr", 64'(dut.ptr), 64'd1);
    tick();
    chk("single_pulse_end", 64'(resp_valid), 64'h0);

    // Move ptr to 0 via requester 3
    req = 4'b1000; req_addr[3] = 5'd1;
    #1;
    chk("p0_gnt", 64'(gnt), 64'h8);
    tick();
    req = 4'b0000;
    chk("p0_ptr", 64'(dut.ptr), 64'd0);

    // Oversubscription rotation
    req = 4'b1111;
    req_addr[0] = 5'd10; req_addr[1] = 5'd11; req_addr[2] = 5'd12; req_addr[3] = 5'd13;
    #1;
    chk("ovs1_gnt", 64'(gnt), 64'h3);
    chk("ovs1_rd_addr0", 64'(rd_addr[0]), 64'd10);
    chk("ovs1_rd_addr1", 64'(rd_addr[1]), 64'd11);
    tick();
    chk("ovs1_resp_valid", 64'(resp_valid), 64'h3);
    chk("ovs1_resp_data0", resp_data[0], BASE | 64'd10);
    chk("ovs1_resp_data1", resp_data[1], BASE | 64'd11);
    chk("ovs2_gnt", 64'(gnt), 64'hC);
    chk("ovs2_rd_addr0", 64'(rd_addr[0]), 64'd12);
    chk("ovs2_rd_addr1", 64'(rd_addr[1]), 64'd13);
    tick();
    chk("ovs2_resp_valid", 64'(resp_valid), 64'hC);
    chk("ovs2_resp_data2", resp_data[2], BASE | 64'd12);
    chk("ovs2_resp_data3", resp_data[3], BASE | 64'd13);
    chk("ovs3_gnt", 64'(gnt), 64'h3);
    tick();
    req = 4'b0000;
    chk("ovs3_resp_valid", 64'(resp_valid), 64'h3);
    chk("ovs3_ptr", 64'(dut.ptr), 64'd2);

    // Move ptr to 3 via requester 2, then wrap-around
    req = 4'b0100;
    tick();
    chk("w_ptr3", 64'(dut.ptr), 64'd3);
    req = 4'b1001; req_addr[3] = 5'd20; req_addr[0] = 5'd21;
    #1;
    chk("wrap_gnt", 64'(gnt), 64'h9);
    chk("wrap_rd_addr0", 64'(rd_addr[0]), 64'd20);
    chk("wrap_rd_addr1", 64'(rd_addr[1]), 64'd21);
    tick();
    req = 4'b0000;
    chk("wrap_resp_valid", 64'(resp_valid), 64'h9);
    chk("wrap_resp_data3", resp_data[3], 64'hAAAA_0000_0000_0014);
    chk("wrap_resp_data0", resp_data[0], 64'hAAAA_0000_0000_0015);
    chk("wrap_ptr", 64'(dut.ptr), 64'd1);

    // Idle for 5 cycles
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_gnt", 64'(gnt), 64'h0);
      chk("idle_rd_addr", 64'(rd_addr), 64'h0);
      tick();
      chk("idle_resp_valid", 64'(resp_valid), 64'h0);
    end
    chk("idle_ptr", 64'(dut.ptr), 64'd1);
    chk("idle_resp_data0", resp_data[0], 64'hAAAA_0000_0000_0015);
    chk("idle_resp_data3", resp_data[3], 64'hAAAA_0000_0000_0014);

    // Back-to-back grants to a lone requester
    req = 4'b0010; req_addr[1] = 5'd3;
    #1;
    chk("b2b1_gnt", 64'(gnt), 64'h2);
    chk("b2b1_rd_addr1", 64'(rd_addr[1]), 64'd0);
    tick();
    chk("b2b1_resp_valid", 64'(resp_valid), 64'h2);
    chk("b2b2_gnt", 64'(gnt), 64'h2);
    tick();
    req = 4'b0000;
    chk("b2b2_resp_valid", 64'(resp_valid), 64'h2);
    chk("b2b_resp_data1", resp_data[1], BASE | 64'd3);

    // Identical addresses each take a port (ptr=2: requester 2 port 0, requester 0 port 1)
    req = 4'b0101; req_addr[0] = 5'd9; req_addr[2] = 5'd9;
    #1;
    chk("same_gnt", 64'(gnt), 64'h5);
    chk("same_rd_addr0", 64'(rd_addr[0]), 64'd9);
    chk("same_rd_addr1", 64'(rd_addr[1]), 64'd9);
    tick();
    chk("same_ptr", 64'(dut.ptr), 64'd1);

    // Async reset between grant and the next edge
    req = 4'b0110;
    #1;
    chk("ar_gnt", 64'(gnt), 64'h6);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt_low", 64'(gnt), 64'h0);
    chk("ar_resp_valid_low", 64'(resp_valid), 64'h0);
    req = 4'b0000;
    tick();
    reset_n = 1'b1;
    tick();
    chk("ar_resp_valid_after", 64'(resp_valid), 64'h0);
    chk("ar_ptr", 64'(dut.ptr), 64'd0);
    req = 4'b1111;
    #1;
    chk("ar_first_gnt", 64'(gnt), 64'h3);
    tick();
    req = 4'b0000;
    chk("ar_ptr2", 64'(dut.ptr), 64'd2);

    // Write-back bypass on addr 7, never on addr 31
    rf[7] = 64'h0; rf[31] = 64'h0;
`ifdef RF_WB_BYPASS_EN
    bypass_exp = 64'h1234;
`else
    bypass_exp = 64'h0;
`endif
    req = 4'b0100; req_addr[2] = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234;
    #1;
    chk("byp7_gnt", 64'(gnt), 64'h4);
    tick();
    chk("byp7_resp_data2", resp_data[2], bypass_exp);
    req_addr[2] = 5'd31; wr_addr = 5'd31;
    #1;
    chk("byp31_gnt", 64'(gnt), 64'h4);
    tick();
    req = 4'b0000; wr_en = 1'b0;
    chk("byp31_resp_data2", resp_data[2], 64'h0);
    chk("byp31_resp_valid", 64'(resp_valid), 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
